// File: rtl/rx_block.sv
// rx_block: 8N1 UART receiver with a mid-bit sampler and a CONTROL/DATA/STATUS register triplet.
// Define RX_MAJORITY_EN to take a 3-sample majority vote at every sample point.
module rx_block #(
  parameter int unsigned BAUD   = 300,
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LINE_IN,
  input  logic [7:0] CONTROL,
  output logic [7:0] DATA,
  output logic [7:0] STATUS
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [7:0]       CMD_ACK  = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             w_deliver, w_frame_err;

  logic [1:0] r_sync;
  logic       w_rx_s;
  logic       w_sample;
  logic       w_ack;

  logic [7:0] r_data;
  logic       r_valid, r_overrun, r_framing, r_busy;

  // Two-flop synchronizer for the asynchronous line, idle-high after reset.
  always_ff @(posedge CLK) begin
    if (RST) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], LINE_IN};
  end

  assign w_rx_s = r_sync[1];
  assign w_ack  = (CONTROL == CMD_ACK);

`ifdef RX_MAJORITY_EN
  // Two previous rx_s values; together with rx_s they form the 3-sample history.
  logic [1:0] r_hist;

  always_ff @(posedge CLK) begin
    if (RST) r_hist <= 2'b11;
    else     r_hist <= {r_hist[0], w_rx_s};
  end

  assign w_sample = (w_rx_s & r_hist[0]) | (w_rx_s & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
  assign w_sample = w_rx_s;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Frame sequencing; the counter is cleared at every sample point so it never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_deliver   = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = w_sample ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = w_sample;
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
          else               w_idx_nxt   = r_idx + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (w_sample) begin
            w_deliver   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_frame_err = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_BREAK: begin
        // A held-low line must return high before a new start bit is accepted.
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Register file; a same-cycle deliver or framing event wins over ACK.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_framing <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_busy    <= (w_state_nxt != S_IDLE);
      if (w_deliver) r_data <= r_shift;
      r_valid   <= w_deliver | (r_valid & ~w_ack);
      r_overrun <= (w_deliver & r_valid & ~w_ack) | (r_overrun & ~w_ack);
      r_framing <= w_frame_err | (r_framing & ~w_ack);
    end
  end

  assign DATA   = r_data;
  assign STATUS = {r_busy, 4'b0000, r_framing, r_overrun, r_valid};

endmodule
